// File: rtl/rr_arb_mux_pkg.sv
// Shared definitions for the round-robin arbitrating mux and its priority picker.
package rr_arb_mux_pkg;

    // Channel index width; a single channel still needs a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

endpackage

// File: rtl/rr_arb_mux_pick.sv
// Combinational rotate-priority encoder: the first request at or after ptr wins, with
// the search wrapping modulo N_IN.
module rr_pick
    import rr_arb_mux_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int IDX_W = idx_width(N_IN)
) (
    input  logic [N_IN-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_IN-1:0]  gnt_onehot,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any
);

    // Walk offsets from farthest to nearest so the nearest request overwrites the rest.
    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        for (int i = N_IN - 1; i >= 0; i--) begin
            int j;
            j = int'(ptr) + i;
            if (j >= N_IN) begin
                j = j - N_IN;
            end
            if (req[j]) begin
                gnt_idx = IDX_W'(j);
                any     = 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_onehot
            assign gnt_onehot[gi] = any && (gnt_idx == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/rr_arb_mux.sv
// N-input round-robin arbitrating mux with one registered output beat and valid/ready
// on every port. Optional grant locking is enabled by defining RR_ARB_MUX_LOCK_EN.
module rr_arb_mux
    import rr_arb_mux_pkg::*;
#(
    parameter int N_IN = 4,
    parameter int W    = 32,
    localparam int IDX_W = idx_width(N_IN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_IN-1:0]   in_valid,
    input  logic [N_IN*W-1:0] in_data,
`ifdef RR_ARB_MUX_LOCK_EN
    input  logic [N_IN-1:0]   in_lock,
`endif
    output logic [N_IN-1:0]   in_ready,
    output logic              out_valid,
    output logic [W-1:0]      out_data,
    output logic [IDX_W-1:0]  out_sel,
    input  logic              out_ready
);

    logic             out_valid_reg;
    logic [W-1:0]     out_data_reg;
    logic [IDX_W-1:0] out_sel_reg;
    logic [IDX_W-1:0] rr_ptr_reg;

    logic [N_IN-1:0]  req;
    logic [N_IN-1:0]  gnt_onehot;
    logic [IDX_W-1:0] gnt_idx;
    logic             any;
    logic             load_en;
    logic [IDX_W-1:0] ptr_next;
    logic [W-1:0]     sel_data;
    logic [W-1:0]     ch_data [N_IN];

    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_split
            assign ch_data[gi] = in_data[gi*W +: W];
        end
    endgenerate

`ifdef RR_ARB_MUX_LOCK_EN
    lock_state_t      state_reg;
    logic [IDX_W-1:0] lock_ch_reg;
    logic [N_IN-1:0]  lock_mask;
    logic             lock_hit;

    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_lock_mask
            assign lock_mask[gi] = (lock_ch_reg == IDX_W'(gi));
        end
    endgenerate

    // While locked only the owning channel may compete.
    assign req      = (state_reg == LOCKED) ? (in_valid & lock_mask) : in_valid;
    assign lock_hit = |(in_lock & gnt_onehot);
`else
    assign req = in_valid;
`endif

    rr_pick #(
        .N_IN  (N_IN),
        .IDX_W (IDX_W)
    ) u_pick (
        .req        (req),
        .ptr        (rr_ptr_reg),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any        (any)
    );

    assign load_en  = !out_valid_reg || out_ready;
    assign in_ready = (load_en && !rst) ? gnt_onehot : '0;
    assign ptr_next = (gnt_idx == IDX_W'(N_IN - 1)) ? '0 : gnt_idx + IDX_W'(1);

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (gnt_onehot[k]) begin
                sel_data = sel_data | ch_data[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_sel_reg   <= '0;
            rr_ptr_reg    <= '0;
`ifdef RR_ARB_MUX_LOCK_EN
            state_reg     <= UNLOCKED;
            lock_ch_reg   <= '0;
`endif
        end else if (load_en) begin
            out_valid_reg <= any;
            if (any) begin
                out_data_reg <= sel_data;
                out_sel_reg  <= gnt_idx;
`ifdef RR_ARB_MUX_LOCK_EN
                // A locking beat pins the grant and freezes the pointer; the first
                // unlocked beat from the owner releases and advances past it.
                if (lock_hit) begin
                    state_reg   <= LOCKED;
                    lock_ch_reg <= gnt_idx;
                end else begin
                    state_reg   <= UNLOCKED;
                    rr_ptr_reg  <= ptr_next;
                end
`else
                rr_ptr_reg   <= ptr_next;
`endif
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_sel   = out_sel_reg;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: a 4-channel and a 3-channel instance with hand-computed
// expectations; lock behaviour is checked when RR_ARB_MUX_LOCK_EN is defined.
module tb_rr_arb_mux;

    logic         clk = 1'b0;
    logic         rst;

    logic [3:0]   in_valid4;
    logic [127:0] in_data4;
    logic [3:0]   in_ready4;
    logic         out_valid4;
    logic [31:0]  out_data4;
    logic [1:0]   out_sel4;
    logic         out_ready4;
`ifdef RR_ARB_MUX_LOCK_EN
    logic [3:0]   in_lock4;
    logic [2:0]   in_lock3;
`endif

    logic [2:0]   in_valid3;
    logic [95:0]  in_data3;
    logic [2:0]   in_ready3;
    logic         out_valid3;
    logic [31:0]  out_data3;
    logic [1:0]   out_sel3;
    logic         out_ready3;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    rr_arb_mux #(.N_IN(4), .W(32)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid4),
        .in_data   (in_data4),
`ifdef RR_ARB_MUX_LOCK_EN
        .in_lock   (in_lock4),
`endif
        .in_ready  (in_ready4),
        .out_valid (out_valid4),
        .out_data  (out_data4),
        .out_sel   (out_sel4),
        .out_ready (out_ready4)
    );

    rr_arb_mux #(.N_IN(3), .W(32)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid3),
        .in_data   (in_data3),
`ifdef RR_ARB_MUX_LOCK_EN
        .in_lock   (in_lock3),
`endif
        .in_ready  (in_ready3),
        .out_valid (out_valid3),
        .out_data  (out_data3),
        .out_sel   (out_sel3),
        .out_ready (out_ready3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_beat4(input string tag, input logic [31:0] data, input logic [1:0] sel);
        chk({tag, "_valid"}, 64'(out_valid4), 64'd1);
        chk({tag, "_data"},  64'(out_data4),  64'(data));
        chk({tag, "_sel"},   64'(out_sel4),   64'(sel));
        $display("beat %s: valid=%0d data=%0h sel=%0d", tag, out_valid4, out_data4, out_sel4);
    endtask

    initial begin
        rst        = 1'b1;
        in_valid4  = 4'b1111;
        in_data4   = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        out_ready4 = 1'b1;
        in_valid3  = 3'b000;
        in_data3   = {32'hB2, 32'hB1, 32'hB0};
        out_ready3 = 1'b1;
`ifdef RR_ARB_MUX_LOCK_EN
        in_lock4   = 4'b0000;
        in_lock3   = 3'b000;
`endif

        // Reset held three cycles with every channel requesting.
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_in_ready", 64'(in_ready4), 64'h0);
            chk("rst_out_valid", 64'(out_valid4), 64'h0);
            chk("rst_out_data", 64'(out_data4), 64'h0);
        end
        rst = 1'b0;
        #1;
        chk("first_in_ready", 64'(in_ready4), 64'b0001);

        // Fairness: all valid, one beat per cycle in channel order.
        tick(); chk_beat4("fair0", 32'hA0, 2'd0);
        tick(); chk_beat4("fair1", 32'hA1, 2'd1);
        tick(); chk_beat4("fair2", 32'hA2, 2'd2);
        tick(); chk_beat4("fair3", 32'hA3, 2'd3);
        tick(); chk_beat4("fair4", 32'hA0, 2'd0);
        tick(); chk_beat4("fair5", 32'hA1, 2'd1);

        // Backpressure holds the 0xA1 beat and blocks every input.
        out_ready4 = 1'b0;
        #1;
        chk("bp_in_ready", 64'(in_ready4), 64'h0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_beat4("bp_hold", 32'hA1, 2'd1);
            chk("bp_hold_in_ready", 64'(in_ready4), 64'h0);
        end
        out_ready4 = 1'b1;
        #1;
        chk("bp_release_in_ready", 64'(in_ready4), 64'b0100);
        tick(); chk_beat4("bp_next", 32'hA2, 2'd2);

        // Sparse wrap: bring rr_ptr to 2 via a lone ch1 beat, then only ch1/ch3 request.
        in_valid4 = 4'b0010;
        #1;
        chk("sp_prime_in_ready", 64'(in_ready4), 64'b0010);
        tick(); chk_beat4("sp_prime", 32'hA1, 2'd1);
        in_valid4 = 4'b1010;
        #1;
        chk("sp_in_ready0", 64'(in_ready4), 64'b1000);
        tick(); chk_beat4("sp0", 32'hA3, 2'd3);
        chk("sp_in_ready1", 64'(in_ready4), 64'b0010);
        tick(); chk_beat4("sp1", 32'hA1, 2'd1);
        tick(); chk_beat4("sp2", 32'hA3, 2'd3);

        // No requests with the output draining: valid drops.
        in_valid4 = 4'b0000;
        tick();
        chk("idle_out_valid", 64'(out_valid4), 64'h0);
        $display("idle: valid=%0d", out_valid4);

        // Reset while a beat is held under backpressure drops it.
        in_valid4 = 4'b0001;
        tick(); chk_beat4("pre_rst", 32'hA0, 2'd0);
        out_ready4 = 1'b0;
        tick(); chk_beat4("pre_rst_hold", 32'hA0, 2'd0);
        rst = 1'b1;
        out_ready4 = 1'b1;
        #1;
        chk("rst_mid_in_ready", 64'(in_ready4), 64'h0);
        tick();
        chk("rst_mid_out_valid", 64'(out_valid4), 64'h0);
        chk("rst_mid_out_data", 64'(out_data4), 64'h0);
        $display("mid reset: valid=%0d data=%0h", out_valid4, out_data4);
        rst = 1'b0;

        // Prime rr_ptr to 1 with a lone ch0 beat, then ch0..ch2 request.
        tick(); chk_beat4("lk_prime", 32'hA0, 2'd0);
        in_valid4 = 4'b0111;
`ifdef RR_ARB_MUX_LOCK_EN
        in_lock4 = 4'b0010;
        tick(); chk_beat4("lk0", 32'hA1, 2'd1);
        chk("lk_in_ready", 64'(in_ready4), 64'b0010);
        tick(); chk_beat4("lk1", 32'hA1, 2'd1);
        tick(); chk_beat4("lk2", 32'hA1, 2'd1);
        in_lock4 = 4'b0000;
        tick(); chk_beat4("lk3", 32'hA1, 2'd1);
        tick(); chk_beat4("lk_release", 32'hA2, 2'd2);
`else
        tick(); chk_beat4("rr0", 32'hA1, 2'd1);
        tick(); chk_beat4("rr1", 32'hA2, 2'd2);
        tick(); chk_beat4("rr2", 32'hA0, 2'd0);
        tick(); chk_beat4("rr3", 32'hA1, 2'd1);
`endif

        // Three channels: wrap must return to 0 without ever visiting index 3.
        in_valid3 = 3'b111;
        tick();
        chk("n3_sel0", 64'(out_sel3), 64'd0);
        chk("n3_data0", 64'(out_data3), 64'hB0);
        chk("n3_ptr0", 64'(dut3.rr_ptr_reg < 2'd3), 64'd1);
        tick();
        chk("n3_sel1", 64'(out_sel3), 64'd1);
        chk("n3_ptr1", 64'(dut3.rr_ptr_reg < 2'd3), 64'd1);
        tick();
        chk("n3_sel2", 64'(out_sel3), 64'd2);
        chk("n3_data2", 64'(out_data3), 64'hB2);
        chk("n3_ptr2", 64'(dut3.rr_ptr_reg), 64'd0);
        tick();
        chk("n3_sel3", 64'(out_sel3), 64'd0);
        chk("n3_valid3", 64'(out_valid3), 64'd1);
        $display("n3: final sel=%0d data=%0h", out_sel3, out_data3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
Parametrised N-input, W-bit round-robin arbitrating multiplexer with a registered output stage and a valid/ready handshake on every port. It is the sequential successor to the pipeline's plain operand/select muxes. It shares one downstream consumer (write-back port, memory port, forwarding bus) among several producers without starvation. Grant is re-arbitrated every cycle, and the output is held stable under backpressure.

Parameters:
N_IN, 4, number of input channels (>=1; need not be a power of two)
W, 32, data width in bits
IDX_W (localparam), max(1, $clog2(N_IN)), width of channel index

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
in_valid  in  N_IN  per-channel request
in_data  in  N_IN*W  flattened channel data; channel k occupies bits [k*W +: W]
in_ready  out  N_IN  per-channel accept; combinational, one-hot or zero
out_valid  out  1  registered output valid
out_data  out  W  registered output data
out_sel  out  IDX_W  index of the channel that supplied out_data
out_ready  in  1  downstream accept

Behaviour:
- Reset (synchronous, active-high):
  - out_valid=0, out_data=0, out_sel=0, rr_ptr=0.
  - in_ready=0 while rst=1.
  - A reset mid-operation drops any held output beat.
- load_en = !out_valid || out_ready.
- Grant: g = first channel with in_valid=1, searching rr_ptr, rr_ptr+1, ... and wrapping modulo N_IN.
- When load_en=1 and g exists:
  - in_ready[g]=1; all other in_ready bits are 0.
  - On the clock edge: out_valid<=1, out_data<=in_data[g], out_sel<=g, rr_ptr<=(g+1) mod N_IN.
  - The wrap goes to 0 at N_IN even when N_IN is not a power of two.
- When load_en=1 and no channel is valid: out_valid<=0, rr_ptr unchanged, in_ready=0.
- When load_en=0 (out_valid=1 and out_ready=0):
  - in_ready=0.
  - out_valid, out_data, out_sel and rr_ptr hold.
- Latency: 1 cycle from input handshake to out_valid.
- Throughput: 1 beat per cycle when out_ready is held high (output drains and reloads in the same cycle).
- in_valid may drop without a handshake; arbitration is purely combinational on the current cycle's inputs.
- The block holds no storage beyond the output register and rr_ptr: it never buffers more than one beat.
- N_IN=1: always grant channel 0; out_sel is always 0.

Optional Feature:
Macro RR_ARB_MUX_LOCK_EN.
- Defined:
  - Adds input port in_lock [N_IN].
  - If a transfer from channel g completes with in_lock[g]=1, a lock state pins the grant to g. Only channel g can be granted, the other in_ready bits stay 0, and rr_ptr does not advance.
  - The lock releases on the first transfer from g with in_lock[g]=0; rr_ptr then becomes (g+1) mod N_IN.
  - Lock is cleared by rst.
  - While locked, if g is not valid, no channel is granted.
- Undefined: the port is absent and the block is pure round-robin.

Decomposition:
- Shared package/header: localparam helper for IDX_W (clog2 with minimum 1).
- Sub-module rr_pick: combinational rotate-priority encoder.
  - Inputs: req[N_IN], ptr[IDX_W].
  - Outputs: gnt_onehot[N_IN], gnt_idx[IDX_W], any.
  - Reusable by other arbiters in the pipeline.
- Top level holds the output register, rr_ptr and the optional lock FSM (states UNLOCKED/LOCKED).

Test Plan:
- Reset: hold rst 3 cycles with in_valid=4'b1111 -> in_ready=0000, out_valid=0, out_data=0. First grant after release is ch0 (out_sel=0 on the next cycle).
- Fairness: N_IN=4, all valid continuously, in_data[k]=0xA0+k, out_ready=1 -> out_data 0xA0,0xA1,0xA2,0xA3,0xA0 with out_sel 0,1,2,3,0, one beat per cycle.
- Backpressure: after 0xA1 is output, hold out_ready=0 for 3 cycles -> out_data stays 0xA1, out_sel=1, in_ready=0000. Raise out_ready -> next beat is ch2 (0xA2).
- Sparse wrap: rr_ptr=2, only ch1 and ch3 valid -> ch3 granted first, then ch1, then ch3.
- Non-power-of-two: N_IN=3, all valid -> out_sel sequence 0,1,2,0; rr_ptr never equals 3.
- Lock (RR_ARB_MUX_LOCK_EN):
  - Stimulus: ch0/ch1/ch2 valid; ch1 asserts in_lock=1 for 3 beats, then 0 on its 4th beat; rr_ptr=1.
  - Required: four consecutive ch1 beats, then ch2.
  - Without the macro: grants alternate 1,2,0,1.
